// File: rtl/clock_pkg.sv
`default_nettype none
//======================================================================
// clock_pkg : state encoding, BCD limits and helper for clock_time_ctrl
// Revision  : 1.0
//======================================================================
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_BAD      = 2'b11
    } state_e;

    localparam logic [7:0] SEC_MAX_BCD    = 8'h59;
    localparam logic [7:0] HOUR24_MAX_BCD = 8'h23;
    localparam logic [7:0] HOUR12_MAX_BCD = 8'h11;

    function automatic logic [7:0] to_bcd(input int unsigned v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 10);
        units = 4'(v % 10);
        return {tens, units};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
//======================================================================
// bcd_mod_counter : two-digit BCD counter wrapping MAX_BCD -> 00
// Revision        : 1.0
//======================================================================
module bcd_mod_counter #(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] q,
    output logic       co
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 8'h00;
        end else if (en) begin
            if (q_q == MAX_BCD) begin
                q_d = 8'h00;
            end else if (q_q[3:0] == 4'd9) begin
                q_d = {q_q[7:4] + 4'd1, 4'd0};
            end else begin
                q_d = {q_q[7:4], q_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge CP) begin
        if (!CR) begin
            q_q <= 8'h00;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign co = en & (q_q == MAX_BCD);

endmodule
`default_nettype wire

// File: rtl/clock_time_ctrl.sv
`default_nettype none
//======================================================================
// clock_time_ctrl : HH:MM:SS timekeeping with button-driven set mode
// Revision        : 1.0
//======================================================================
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int HOUR_MAX = 23,
    parameter int SEC_MAX  = 59
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic [1:0] mode,
    output logic       blink_hour,
    output logic       blink_min,
    output logic       day_co
);

    localparam logic [7:0] c_HOUR_MAX_BCD = (HOUR_MAX == 11) ? HOUR12_MAX_BCD : HOUR24_MAX_BCD;
    localparam logic [7:0] c_SEC_MAX_BCD  = to_bcd(SEC_MAX);

    state_e state_q;
    state_e state_d;
    logic   mode_prev_q;
    logic   inc_prev_q;
    logic   phase_q;
    logic   phase_d;
    logic   day_co_q;
    logic   day_co_d;

    logic w_mode_press;
    logic w_inc_eff;
    logic w_sec_en;
    logic w_min_en;
    logic w_hour_en;
    logic w_sec_clr;
    logic w_sec_co;
    logic w_min_co;
    logic w_hour_co;

    assign w_mode_press = btn_mode & ~mode_prev_q;
    // A mode press in the same cycle swallows any increment press.
    assign w_inc_eff    = btn_inc & ~inc_prev_q & ~w_mode_press;

    always_comb begin
        state_d   = state_q;
        w_sec_en  = 1'b0;
        w_min_en  = 1'b0;
        w_hour_en = 1'b0;
        w_sec_clr = 1'b0;
        case (state_q)
            ST_RUN: begin
                w_sec_en  = tick_1hz;
                w_min_en  = w_sec_co;
                w_hour_en = w_min_co;
                if (w_mode_press) state_d = ST_SET_HOUR;
            end
            ST_SET_HOUR: begin
                w_hour_en = w_inc_eff;
                if (w_mode_press) state_d = ST_SET_MIN;
            end
            ST_SET_MIN: begin
                w_min_en = w_inc_eff;
                if (w_mode_press) begin
                    state_d   = ST_RUN;
                    w_sec_clr = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        if ((state_d != state_q) || (state_q == ST_RUN)) begin
            phase_d = 1'b0;
        end else if (tick_1hz) begin
            phase_d = ~phase_q;
        end
    end

    // Hour wraps from set mode must never look like a day rollover.
    assign day_co_d = w_hour_co & (state_q == ST_RUN);

    always_ff @(posedge CP) begin
        if (!CR) begin
            state_q     <= ST_RUN;
            mode_prev_q <= 1'b1;
            inc_prev_q  <= 1'b1;
            phase_q     <= 1'b0;
            day_co_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= btn_mode;
            inc_prev_q  <= btn_inc;
            phase_q     <= phase_d;
            day_co_q    <= day_co_d;
        end
    end

    bcd_mod_counter #(.MAX_BCD(c_SEC_MAX_BCD)) u_sec (
        .CP (CP),
        .CR (CR),
        .en (w_sec_en),
        .clr(w_sec_clr),
        .q  (sec_bcd),
        .co (w_sec_co)
    );

    bcd_mod_counter #(.MAX_BCD(c_SEC_MAX_BCD)) u_min (
        .CP (CP),
        .CR (CR),
        .en (w_min_en),
        .clr(1'b0),
        .q  (min_bcd),
        .co (w_min_co)
    );

    bcd_mod_counter #(.MAX_BCD(c_HOUR_MAX_BCD)) u_hour (
        .CP (CP),
        .CR (CR),
        .en (w_hour_en),
        .clr(1'b0),
        .q  (hour_bcd),
        .co (w_hour_co)
    );

    assign mode       = state_q;
    assign blink_hour = (state_q == ST_SET_HOUR) & phase_q;
    assign blink_min  = (state_q == ST_SET_MIN) & phase_q;
    assign day_co     = day_co_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_time_ctrl.sv
`default_nettype none
//======================================================================
// tb_clock_time_ctrl : scoreboard bench for clock_time_ctrl
// Revision           : 1.0
//======================================================================
module tb_clock_time_ctrl;

    localparam logic [1:0] RUN  = 2'b00;
    localparam logic [1:0] SETH = 2'b01;
    localparam logic [1:0] SETM = 2'b10;

    logic       CP = 1'b0;
    logic       CR = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hour_bcd;
    logic [1:0] mode;
    logic       blink_hour;
    logic       blink_min;
    logic       day_co;

    clock_time_ctrl dut (
        .CP        (CP),
        .CR        (CR),
        .tick_1hz  (tick_1hz),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .hour_bcd  (hour_bcd),
        .mode      (mode),
        .blink_hour(blink_hour),
        .blink_min (blink_min),
        .day_co    (day_co)
    );

    always #5 CP = ~CP;

    typedef struct {
        string      name;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [1:0] md;
        logic       bh;
        logic       bm;
        logic       dc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin
        forever begin
            @(negedge CP);
            while (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if ({hour_bcd, min_bcd, sec_bcd, mode, blink_hour, blink_min, day_co} !==
                    {e.h, e.m, e.s, e.md, e.bh, e.bm, e.dc}) begin
                    n_bad++;
                    $display("FAIL %s: got %h:%h:%h mode=%b bh=%b bm=%b dco=%b, expected %h:%h:%h mode=%b bh=%b bm=%b dco=%b",
                             e.name, hour_bcd, min_bcd, sec_bcd, mode, blink_hour, blink_min, day_co,
                             e.h, e.m, e.s, e.md, e.bh, e.bm, e.dc);
                end
            end
        end
    end

    task automatic cyc(input logic t, input logic m, input logic i);
        tick_1hz = t;
        btn_mode = m;
        btn_inc  = i;
        @(posedge CP);
        #1;
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s, input logic [1:0] md,
                       input logic bh, input logic bm, input logic dc);
        exp_t e;
        e.name = nm; e.h = h; e.m = m; e.s = s; e.md = md; e.bh = bh; e.bm = bm; e.dc = dc;
        sb.push_back(e);
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic mode_p();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        repeat (n) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // reset
        CR = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("reset", 8'h00, 8'h00, 8'h00, RUN, 1'b0, 1'b0, 1'b0);
        CR = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);

        // 60 ticks
        ticks(9);
        chk("tick9", 8'h00, 8'h00, 8'h09, RUN, 1'b0, 1'b0, 1'b0);
        ticks(1);
        chk("tick10", 8'h00, 8'h00, 8'h10, RUN, 1'b0, 1'b0, 1'b0);
        ticks(49);
        chk("tick59", 8'h00, 8'h00, 8'h59, RUN, 1'b0, 1'b0, 1'b0);
        ticks(1);
        chk("tick60", 8'h00, 8'h01, 8'h00, RUN, 1'b0, 1'b0, 1'b0);

        // preload 23:59:58 and roll the day
        mode_p();
        incs(23);
        chk("seth23", 8'h23, 8'h01, 8'h00, SETH, 1'b0, 1'b0, 1'b0);
        mode_p();
        incs(58);
        chk("setm59", 8'h23, 8'h59, 8'h00, SETM, 1'b0, 1'b0, 1'b0);
        mode_p();
        ticks(58);
        chk("pre58", 8'h23, 8'h59, 8'h58, RUN, 1'b0, 1'b0, 1'b0);
        ticks(1);
        chk("pre59", 8'h23, 8'h59, 8'h59, RUN, 1'b0, 1'b0, 1'b0);
        ticks(1);
        chk("dayroll", 8'h00, 8'h00, 8'h00, RUN, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("daycopulse", 8'h00, 8'h00, 8'h00, RUN, 1'b0, 1'b0, 1'b0);

        // hour stepping with frozen ticks
        mode_p();
        incs(12);
        cyc(1'b1, 1'b0, 1'b0);
        chk("frz_blink", 8'h12, 8'h00, 8'h00, SETH, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("frz_blink2", 8'h12, 8'h00, 8'h00, SETH, 1'b0, 1'b0, 1'b0);
        incs(11);
        chk("h23", 8'h23, 8'h00, 8'h00, SETH, 1'b0, 1'b0, 1'b0);
        incs(1);
        chk("hwrap", 8'h00, 8'h00, 8'h00, SETH, 1'b0, 1'b0, 1'b0);
        incs(1);
        chk("h01", 8'h01, 8'h00, 8'h00, SETH, 1'b0, 1'b0, 1'b0);

        // minute wrap with sec=37, exit clears seconds
        mode_p();
        mode_p();
        ticks(37);
        chk("sec37", 8'h01, 8'h00, 8'h37, RUN, 1'b0, 1'b0, 1'b0);
        mode_p();
        mode_p();
        incs(59);
        chk("m59", 8'h01, 8'h59, 8'h37, SETM, 1'b0, 1'b0, 1'b0);
        incs(1);
        chk("mwrap", 8'h01, 8'h00, 8'h37, SETM, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("mblink", 8'h01, 8'h00, 8'h37, SETM, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("exitclr", 8'h01, 8'h00, 8'h00, RUN, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // simultaneous mode+inc, held inc
        mode_p();
        cyc(1'b0, 1'b1, 1'b1);
        chk("modewins", 8'h01, 8'h00, 8'h00, SETM, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 1'b1);
        chk("heldinc", 8'h01, 8'h01, 8'h00, SETM, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        mode_p();

        // reset during the 23:59:59 tick
        mode_p();
        incs(22);
        mode_p();
        incs(58);
        mode_p();
        ticks(59);
        chk("at235959", 8'h23, 8'h59, 8'h59, RUN, 1'b0, 1'b0, 1'b0);
        CR       = 1'b0;
        tick_1hz = 1'b1;
        btn_mode = 1'b1;
        @(posedge CP);
        #1;
        tick_1hz = 1'b0;
        CR       = 1'b1;
        chk("rstmid", 8'h00, 8'h00, 8'h00, RUN, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge CP);
            #1;
        end
        chk("heldmode", 8'h00, 8'h00, 8'h00, RUN, 1'b0, 1'b0, 1'b0);
        btn_mode = 1'b0;
        @(posedge CP);
        #1;
        chk("relmode", 8'h00, 8'h00, 8'h00, RUN, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge CP);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
